// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS IF/DM memory arbiter.
// Used by mips_mem_arbiter and arb_starve_counter.
package mips_mem_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_MEM_LAT    = 1;
  localparam int unsigned DEF_STARVE_MAX = 4;

  // Counter width able to hold max_val; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating aging counter for the IF requester; starve is high once the
// count has reached STARVE_MAX (never when STARVE_MAX is 0).
module arb_starve_counter
  import mips_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic starve
);

  localparam int unsigned CNT_W = cnt_width(STARVE_MAX);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (inc && (cnt != CNT_W'(STARVE_MAX))) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      starve <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      starve <= (STARVE_MAX != 0) && (cnt_nxt == CNT_W'(STARVE_MAX));
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Shares one fixed-latency memory between MIPS fetch (IF) and load/store (DM).
// Optional macro ARB_PERF_CNT_EN adds perf_conflict / perf_if_stall counters.
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_conflict,
  output logic [31:0]       perf_if_stall
`endif
);

  localparam int unsigned LAT_W = cnt_width(MEM_LAT);

  arb_state_e       state;
  logic [LAT_W-1:0] lat_cnt;
  logic             owner;
  logic             owner_we;

  logic done;
  logic eligible;
  logic starve;
  logic dm_win;
  logic if_win;
  logic gnt_any;
  logic cap;
  logic cap_owner;
  logic cap_we;

  // Grant decode: reset gates everything so outputs are 0 while RST is low.
  always_comb begin
    done      = (state == ARB_WAIT) && (lat_cnt == LAT_W'(MEM_LAT));
    eligible  = RST && ((state == ARB_IDLE) || done);
    dm_win    = eligible && dm_req && !(if_req && starve);
    if_win    = eligible && if_req && !dm_win;
    gnt_any   = dm_win || if_win;
    if_gnt    = if_win;
    dm_gnt    = dm_win;
    mem_en    = gnt_any;
    mem_we    = dm_win && dm_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_win) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_win) begin
      mem_addr  = if_addr;
    end
    // Capture edge is the one ending the cycle before completion.
    if (MEM_LAT == 1) begin
      cap       = gnt_any;
      cap_owner = dm_win ? REQ_DM : REQ_IF;
      cap_we    = mem_we;
    end else begin
      cap       = (state == ARB_WAIT) && (lat_cnt == LAT_W'(MEM_LAT - 1));
      cap_owner = owner;
      cap_we    = owner_we;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ARB_IDLE;
      lat_cnt   <= '0;
      owner     <= REQ_IF;
      owner_we  <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      rdata     <= '0;
    end else begin
      if_rvalid <= cap && (cap_owner == REQ_IF);
      dm_rvalid <= cap && (cap_owner == REQ_DM);
      if (cap && !cap_we) begin
        rdata <= mem_rdata;
      end
      if (gnt_any) begin
        state    <= ARB_WAIT;
        lat_cnt  <= LAT_W'(1);
        owner    <= dm_win ? REQ_DM : REQ_IF;
        owner_we <= mem_we;
      end else if (done) begin
        state    <= ARB_IDLE;
        lat_cnt  <= '0;
      end else if (state == ARB_WAIT) begin
        lat_cnt  <= lat_cnt + LAT_W'(1);
      end
    end
  end

  arb_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk    (CLK),
    .rst_n  (RST),
    .inc    (eligible && if_req && !if_win),
    .clr    (!if_req || if_win),
    .starve (starve)
  );

`ifdef ARB_PERF_CNT_EN
  // Saturating event counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perf_conflict <= '0;
      perf_if_stall <= '0;
    end else begin
      if (eligible && if_req && dm_req && (perf_conflict != '1)) begin
        perf_conflict <= perf_conflict + 32'(1);
      end
      if (if_req && !if_win && (perf_if_stall != '1)) begin
        perf_if_stall <= perf_if_stall + 32'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter (MEM_LAT=2, STARVE_MAX=3) with a
// synchronous memory model; perf counters checked when ARB_PERF_CNT_EN is set.
`timescale 1ns/1ps
module tb_mips_mem_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          if_req, dm_req, dm_we;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef ARB_PERF_CNT_EN
  logic [31:0]   perf_conflict, perf_if_stall;
`endif

  mips_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(3)
  ) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_conflict(perf_conflict), .perf_if_stall(perf_if_stall)
`endif
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory model: one register stage so data lands in the arbiter's rdata
  // register two cycles after the grant.
  logic [DW-1:0] wmem [1024];
  bit            written [1024];

  function automatic logic [DW-1:0] mem_val(input logic [9:0] idx);
    return written[idx] ? wmem[idx] : (32'hC0DE_0000 | 32'(idx));
  endfunction

  always @(posedge CLK) begin
    if (mem_en && mem_we) begin
      wmem[mem_addr[11:2]]    <= mem_wdata;
      written[mem_addr[11:2]] <= 1'b1;
    end
    if (mem_en && !mem_we) mem_rdata <= mem_val(mem_addr[11:2]);
    else                   mem_rdata <= 32'hBAD0_BAD0;
  end

  typedef struct {
    logic          is_dm;
    int            stamp;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb[$];
  sb_t           e;
  logic [DW-1:0] exp_rdata;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wd;
  logic          x_we;

  // Scoreboard: push on grant, pop and compare on rvalid.
  always @(negedge CLK) begin
    if (!RST) begin
      sb.delete();
      exp_rdata = '0;
    end else begin
      if (if_rvalid || dm_rvalid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rvalid_unexpected: got if_rvalid=%b dm_rvalid=%b, required none", if_rvalid, dm_rvalid);
        end else begin
          e = sb.pop_front();
          if ((if_rvalid && dm_rvalid) || (dm_rvalid !== e.is_dm) || (rdata !== e.data)
              || (cyc != e.stamp + int'(LAT))) begin
            miscompares++;
            $display("FAIL completion: got dm=%b rdata=%h cyc=%0d, required dm=%b rdata=%h cyc=%0d",
                     dm_rvalid, rdata, cyc, e.is_dm, e.data, e.stamp + int'(LAT));
          end
        end
      end
      vectors++;
      if (if_gnt || dm_gnt) begin
        x_addr = dm_gnt ? dm_addr : if_addr;
        x_we   = dm_gnt && dm_we;
        x_wd   = dm_gnt ? dm_wdata : '0;
        if ((if_gnt && dm_gnt) || mem_en !== 1'b1 || mem_we !== x_we
            || mem_addr !== x_addr || mem_wdata !== x_wd) begin
          miscompares++;
          $display("FAIL mem_bus_grant: got gnt=%b%b en=%b we=%b addr=%h wd=%h, required en=1 we=%b addr=%h wd=%h",
                   if_gnt, dm_gnt, mem_en, mem_we, mem_addr, mem_wdata, x_we, x_addr, x_wd);
        end
        e.is_dm = dm_gnt;
        e.stamp = cyc;
        e.data  = x_we ? exp_rdata : mem_val(x_addr[11:2]);
        exp_rdata = e.data;
        sb.push_back(e);
      end else if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
        miscompares++;
        $display("FAIL mem_bus_idle: got en=%b we=%b addr=%h wd=%h, required all 0",
                 mem_en, mem_we, mem_addr, mem_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    tick();
    tick();
    RST = 1'b1;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, required 0", sb.size());
    end
  endtask

  // Waits (bounded) for a grant, returning at the negedge of the grant cycle.
  task automatic wait_gnt(input logic is_dm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (is_dm ? dm_gnt : if_gnt) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    bit ok;
    RST = 1'b0;
    tick();
    tick();
    @(negedge CLK);
    vectors++;
    if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we} !== 6'b0 || rdata !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got ctl=%b rdata=%h, required 0", {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we}, rdata);
    end
    tick();
    RST = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 32'h10;
    wait_gnt(1'b0, ok);
    tick();
    if_req = 1'b0;
    drain();
    if_req = 1'b1; if_addr = 32'h20;
    wait_gnt(1'b0, ok);
    tick();
    if_req = 1'b0;
    #2 RST = 1'b0;
    #1;
    vectors++;
    if ({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we} !== 6'b0 || rdata !== '0
        || mem_addr !== '0 || mem_wdata !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_wait: got ctl=%b rdata=%h addr=%h, required 0",
               {if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we}, rdata, mem_addr);
    end
    tick();
    tick();
    RST = 1'b1;
    if_req = 1'b1; if_addr = 32'h0;
    @(negedge CLK);
    vectors++;
    if (if_gnt !== 1'b1 || mem_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_first_gnt: got if_gnt=%b addr=%h, required 1 00000000", if_gnt, mem_addr);
    end
    tick();
    if_req = 1'b0;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    vectors++;
    if (if_rvalid !== 1'b1 || rdata !== 32'hC0DE_0000) begin
      miscompares++;
      $display("FAIL reset_first_rvalid: got if_rvalid=%b rdata=%h, required 1 c0de0000", if_rvalid, rdata);
    end
    drain();
  endtask

  task automatic test_conflict();
    do_reset();
    if_req = 1'b1; if_addr = 32'h4;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    @(negedge CLK);
    vectors++;
    if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_first: got dm_gnt=%b if_gnt=%b, required 1 0", dm_gnt, if_gnt);
    end
    tick();
    dm_req = 1'b0;
    @(negedge CLK);
    vectors++;
    if (dm_gnt !== 1'b0 || if_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL conflict_wait_nogrant: got dm_gnt=%b if_gnt=%b, required 0 0", dm_gnt, if_gnt);
    end
    tick();
    @(negedge CLK);
    vectors++;
    if (if_gnt !== 1'b1 || dm_rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL conflict_handoff: got if_gnt=%b dm_rvalid=%b, required 1 1", if_gnt, dm_rvalid);
    end
    tick();
    if_req = 1'b0;
    @(negedge CLK);
    tick();
    @(negedge CLK);
    vectors++;
    if (if_rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL conflict_if_rvalid: got %b, required 1", if_rvalid);
    end
`ifdef ARB_PERF_CNT_EN
    vectors++;
    if (perf_conflict !== 32'd1 || perf_if_stall !== 32'd2) begin
      miscompares++;
      $display("FAIL perf_counters: got conflict=%0d stall=%0d, required 1 2", perf_conflict, perf_if_stall);
    end
`endif
    drain();
  endtask

  task automatic test_starvation();
    logic [7:0] pat;
    int k;
    pat = '0;
    k = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300;
    if_req = 1'b1; if_addr = 32'h8;
    for (int i = 0; i < 40 && k < 8; i++) begin
      @(negedge CLK);
      if (if_gnt || dm_gnt) begin
        pat[k] = if_gnt;
        k++;
      end
      tick();
    end
    dm_req = 1'b0;
    if_req = 1'b0;
    vectors++;
    if (k != 8 || pat !== 8'b1000_1000) begin
      miscompares++;
      $display("FAIL starvation_pattern: got k=%0d pat=%b, required 8 10001000", k, pat);
    end
    drain();
  endtask

  task automatic test_write();
    bit ok;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEAD_BEEF;
    wait_gnt(1'b1, ok);
    vectors++;
    if (!ok || mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h200) begin
      miscompares++;
      $display("FAIL write_issue: got ok=%b we=%b wd=%h addr=%h, required 1 1 deadbeef 00000200", ok, mem_we, mem_wdata, mem_addr);
    end
    tick();
    dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0;
    @(negedge CLK);
    vectors++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_wdata !== '0) begin
      miscompares++;
      $display("FAIL write_one_cycle: got en=%b we=%b wd=%h, required 0 0 0", mem_en, mem_we, mem_wdata);
    end
    drain();
    dm_req = 1'b1; dm_addr = 32'h200;
    wait_gnt(1'b1, ok);
    tick();
    dm_req = 1'b0;
    drain();
    vectors++;
    if (!ok || rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL write_readback: got ok=%b rdata=%h, required 1 deadbeef", ok, rdata);
    end
  endtask

  task automatic test_stream();
    int n, last, bad;
    n = 0; last = 0; bad = 0;
    if_req = 1'b1; if_addr = 32'h400;
    for (int i = 0; i < 40 && n < 10; i++) begin
      @(negedge CLK);
      if (if_gnt) begin
        if (n > 0 && cyc - last != int'(LAT)) bad++;
        last = cyc;
        n++;
        tick();
        if_addr = if_addr + 32'd4;
        if (n == 10) if_req = 1'b0;
      end else begin
        tick();
      end
    end
    if_req = 1'b0;
    vectors++;
    if (n != 10 || bad != 0) begin
      miscompares++;
      $display("FAIL stream_rate: got grants=%0d gaps_off=%0d, required 10 0", n, bad);
    end
    drain();
  endtask

  initial begin
    RST = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    test_reset();
    test_conflict();
    test_starvation();
    test_write();
    test_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
